// File: rtl/tree_inj_pkg.sv
// Shared helpers for the tree NoC injection scheduler: flit field offsets,
// flit width and index-width helpers.
package tree_inj_pkg;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width of an index into n items, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2_f(n) : 1;
    endfunction

    function automatic int fw_f(input int v, input int fpay);
        return 2 + v + fpay;
    endfunction

    function automatic int hdr_pos(input int v, input int fpay);
        return v + fpay + 1;
    endfunction

    function automatic int tail_pos(input int v, input int fpay);
        return v + fpay;
    endfunction

    function automatic int vc_lsb(input int fpay);
        return fpay;
    endfunction

    function automatic int pay_lsb();
        return 0;
    endfunction

    // Source flits carry no VC field: {hdr, tail, payload}
    function automatic int src_hdr_pos(input int fpay);
        return fpay + 1;
    endfunction

    function automatic int src_tail_pos(input int fpay);
        return fpay;
    endfunction

endpackage

// File: rtl/tree_inj_rr_arb.sv
// NS-way round-robin arbiter: one-hot grant to the first requester at or
// after the priority pointer; the pointer moves past the winner on upd_en.
module tree_inj_rr_arb
    import tree_inj_pkg::*;
#(
    parameter int NS = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NS-1:0]          req,
    input  logic                   upd_en,
    output logic [NS-1:0]          grant,
    output logic [idx_w(NS)-1:0]   grant_idx
);

    localparam int PW = idx_w(NS);

    logic [PW-1:0] r_ptr;
    logic          w_found;
    int            w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NS; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NS) w_idx = w_idx - NS;
            if (!w_found && req[w_idx]) begin
                w_found       = 1'b1;
                grant[w_idx]  = 1'b1;
                grant_idx     = PW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (upd_en && w_found) begin
            r_ptr <= (grant_idx == PW'(NS - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/tree_ni_inject_sched.sv
// Injection scheduler: allocates a VC per packet, tracks per-VC credits and
// round-robins flit slots among sources. Optional TREE_INJ_STATS_EN adds counters.
module tree_ni_inject_sched
    import tree_inj_pkg::*;
#(
    parameter int NS   = 4,
    parameter int V    = 2,
    parameter int Fpay = 32,
    parameter int B    = 4
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NS*(2+Fpay)-1:0]      src_flit,
    input  logic [NS-1:0]               src_valid,
    output logic [NS-1:0]               src_ready,
    output logic [fw_f(V, Fpay)-1:0]    flit_out,
    output logic                        flit_out_wr,
    input  logic [V-1:0]                credit_in,
    output logic [V-1:0]                vc_busy
`ifdef TREE_INJ_STATS_EN
   ,output logic [NS*16-1:0]            stat_pkt_cnt,
    output logic [NS*16-1:0]            stat_stall_cnt
`endif
);

    localparam int SW = 2 + Fpay;
    localparam int FW = fw_f(V, Fpay);
    localparam int CW = clog2_f(B + 1);
    localparam int OW = idx_w(NS);
    localparam int VW = idx_w(V);

    logic [CW-1:0]  r_credit [V];
    logic [V-1:0]   r_busy;
    logic [OW-1:0]  r_owner  [V];
    logic [FW-1:0]  r_flit_out;
    logic           r_flit_wr;

    logic [V-1:0]   w_cred_ok;
    logic           w_free_ok;
    logic [VW-1:0]  w_free_vc;
    logic [NS-1:0]  w_hdr, w_tail, w_owns, w_elig, w_req, w_grant;
    logic [VW-1:0]  w_own_vc [NS];
    logic           w_any;
    logic [OW-1:0]  w_win;
    logic           w_win_hdr, w_win_tail;
    logic [VW-1:0]  w_win_vc;
    logic [Fpay-1:0] w_win_pay;
    logic [V-1:0]   w_dec;
    logic [FW-1:0]  w_flit_nxt;

    // Lowest-index free VC with credit is the head-flit candidate
    always_comb begin
        w_free_ok = 1'b0;
        w_free_vc = '0;
        for (int v = V - 1; v >= 0; v--) begin
            w_cred_ok[v] = (r_credit[v] != '0);
            if (!r_busy[v] && (r_credit[v] != '0)) begin
                w_free_ok = 1'b1;
                w_free_vc = VW'(v);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            w_hdr[s]    = src_flit[s*SW + src_hdr_pos(Fpay)];
            w_tail[s]   = src_flit[s*SW + src_tail_pos(Fpay)];
            w_owns[s]   = 1'b0;
            w_own_vc[s] = '0;
            for (int v = 0; v < V; v++) begin
                if (r_busy[v] && (r_owner[v] == OW'(s))) begin
                    w_owns[s]   = 1'b1;
                    w_own_vc[s] = VW'(v);
                end
            end
            w_elig[s] = w_hdr[s] ? (!w_owns[s] && w_free_ok)
                                 : (w_owns[s] && w_cred_ok[w_own_vc[s]]);
        end
        w_req = reset ? '0 : (src_valid & w_elig);
    end

    tree_inj_rr_arb #(.NS(NS)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (w_req),
        .upd_en    (w_any),
        .grant     (w_grant),
        .grant_idx (w_win)
    );

    assign w_any = |w_grant;

    always_comb begin
        w_win_hdr  = w_hdr[w_win];
        w_win_tail = w_tail[w_win];
        w_win_pay  = src_flit[int'(w_win)*SW +: Fpay];
        w_win_vc   = w_win_hdr ? w_free_vc : w_own_vc[w_win];
        w_dec      = '0;
        if (w_any) w_dec[w_win_vc] = 1'b1;
        w_flit_nxt                          = '0;
        w_flit_nxt[hdr_pos(V, Fpay)]        = w_win_hdr;
        w_flit_nxt[tail_pos(V, Fpay)]       = w_win_tail;
        w_flit_nxt[vc_lsb(Fpay) +: V]       = w_dec;
        w_flit_nxt[pay_lsb() +: Fpay]       = w_win_pay;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                r_credit[v] <= CW'(B);
                r_owner[v]  <= '0;
            end
            r_busy     <= '0;
            r_flit_out <= '0;
            r_flit_wr  <= 1'b0;
        end else begin
            r_flit_wr <= w_any;
            if (w_any) r_flit_out <= w_flit_nxt;
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && !w_dec[v]) begin
                    if (r_credit[v] != CW'(B)) r_credit[v] <= r_credit[v] + CW'(1);
                end else if (!credit_in[v] && w_dec[v]) begin
                    r_credit[v] <= r_credit[v] - CW'(1);
                end
                // Tail release wins so a single-flit packet leaves the VC free
                if (w_dec[v]) begin
                    if (w_win_hdr) begin
                        r_busy[v]  <= 1'b1;
                        r_owner[v] <= w_win;
                    end
                    if (w_win_tail) r_busy[v] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < V; v++) begin
                assert (!(credit_in[v] && !w_dec[v] && (r_credit[v] == CW'(B))))
                    else $error("credit overflow on VC %0d", v);
            end
            for (int s = 0; s < NS; s++) begin
                assert (!(src_valid[s] && w_hdr[s] && w_owns[s]))
                    else $warning("protocol: head flit from source %0d that already owns a VC", s);
                assert (!(src_valid[s] && !w_hdr[s] && !w_owns[s]))
                    else $warning("protocol: body flit from source %0d with no VC", s);
            end
        end
    end

    assign src_ready   = w_grant;
    assign flit_out    = r_flit_out;
    assign flit_out_wr = r_flit_wr;
    assign vc_busy     = r_busy;

`ifdef TREE_INJ_STATS_EN
    logic [15:0] r_pkt_cnt   [NS];
    logic [15:0] r_stall_cnt [NS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                r_pkt_cnt[s]   <= '0;
                r_stall_cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (w_grant[s] && w_tail[s]) r_pkt_cnt[s] <= r_pkt_cnt[s] + 16'd1;
                if (src_valid[s] && !w_grant[s]) r_stall_cnt[s] <= r_stall_cnt[s] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            stat_pkt_cnt[s*16 +: 16]   = r_pkt_cnt[s];
            stat_stall_cnt[s*16 +: 16] = r_stall_cnt[s];
        end
    end
`endif

endmodule

// File: tb/tb_tree_ni_inject_sched.sv
// Directed bench for tree_ni_inject_sched with NS=4, V=2, Fpay=32, B=4.
module tb_tree_ni_inject_sched;

    localparam int NS   = 4;
    localparam int V    = 2;
    localparam int Fpay = 32;
    localparam int B    = 4;
    localparam int SW   = 2 + Fpay;
    localparam int FW   = 2 + V + Fpay;

    logic                 clk;
    logic                 reset;
    logic [NS*SW-1:0]     src_flit;
    logic [NS-1:0]        src_valid;
    logic [NS-1:0]        src_ready;
    logic [FW-1:0]        flit_out;
    logic                 flit_out_wr;
    logic [V-1:0]         credit_in;
    logic [V-1:0]         vc_busy;

    int n_run  = 0;
    int n_fail = 0;

    tree_ni_inject_sched #(.NS(NS), .V(V), .Fpay(Fpay), .B(B)) dut (
        .clk         (clk),
        .reset       (reset),
        .src_flit    (src_flit),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .flit_out    (flit_out),
        .flit_out_wr (flit_out_wr),
        .credit_in   (credit_in),
        .vc_busy     (vc_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int s, input logic v, input logic h, input logic t, input logic [31:0] p);
        src_valid[s]         = v;
        src_flit[s*SW +: SW] = {h, t, p};
    endtask

    task automatic clr();
        src_valid = '0;
        src_flit  = '0;
        credit_in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        reset = 1'b1;
        clr();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [FW-1:0] fo(input logic h, input logic t, input logic [1:0] vc, input logic [31:0] p);
        return {h, t, vc, p};
    endfunction

    initial begin
        // Reset values with a head offered while reset is high
        reset = 1'b1;
        clr();
        put(0, 1, 1, 0, 32'h11);
        tick(); tick(); #1;
        chk("rst_ready", src_ready, 4'b0000);
        chk("rst_wr", flit_out_wr, 1'b0);
        chk("rst_flit", flit_out, '0);
        chk("rst_busy", vc_busy, 2'b00);

        // Single source, 3-flit packet on VC0, then credit 1 left
        reset = 1'b0;
        put(0, 1, 1, 0, 32'hA0); #1;
        chk("t1_c0_ready", src_ready, 4'b0001);
        tick(); put(0, 1, 0, 0, 32'hA1); #1;
        chk("t1_c1_ready", src_ready, 4'b0001);
        chk("t1_head", flit_out, fo(1, 0, 2'b01, 32'hA0));
        chk("t1_head_wr", flit_out_wr, 1'b1);
        chk("t1_busy_h", vc_busy, 2'b01);
        tick(); put(0, 1, 0, 1, 32'hA2); #1;
        chk("t1_body", flit_out, fo(0, 0, 2'b01, 32'hA1));
        chk("t1_busy_b", vc_busy, 2'b01);
        tick(); put(0, 1, 1, 0, 32'hA3); #1;
        chk("t1_tail", flit_out, fo(0, 1, 2'b01, 32'hA2));
        chk("t1_busy_t", vc_busy, 2'b00);
        chk("t1_rehead_ready", src_ready, 4'b0001);
        tick(); put(0, 1, 0, 0, 32'hA4); #1;
        chk("t1_rehead", flit_out, fo(1, 0, 2'b01, 32'hA3));
        chk("t1_cred0_ready", src_ready, 4'b0000);
        tick(); #1;
        chk("t1_idle_wr", flit_out_wr, 1'b0);

        // Credit exhaustion: four flits pass, then one per returned credit
        rst();
        put(1, 1, 1, 0, 32'hB0); #1;
        chk("t2_head_ready", src_ready, 4'b0010);
        for (int i = 1; i <= 3; i++) begin
            tick(); put(1, 1, 0, 0, 32'hB0 + i); #1;
            chk("t2_body_ready", src_ready, 4'b0010);
            chk("t2_flit", flit_out, fo(i == 1, 0, 2'b01, 32'hB0 + i - 1));
        end
        tick(); put(1, 1, 0, 0, 32'hB4); #1;
        chk("t2_stall_ready", src_ready, 4'b0000);
        chk("t2_last", flit_out, fo(0, 0, 2'b01, 32'hB3));
        tick(); #1;
        chk("t2_stall_wr", flit_out_wr, 1'b0);
        credit_in = 2'b01; #1;
        chk("t2_no_comb_credit", src_ready, 4'b0000);
        tick(); credit_in = 2'b00; #1;
        chk("t2_release_ready", src_ready, 4'b0010);
        tick(); put(1, 1, 0, 0, 32'hB5); #1;
        chk("t2_release_wr", flit_out_wr, 1'b1);
        chk("t2_release_flit", flit_out, fo(0, 0, 2'b01, 32'hB4));
        chk("t2_restall_ready", src_ready, 4'b0000);
        tick(); #1;
        chk("t2_one_only_wr", flit_out_wr, 1'b0);

        // Two sources, concurrent heads, interleaved on VC0/VC1
        rst();
        put(0, 1, 1, 0, 32'hC0);
        put(2, 1, 1, 0, 32'hD0); #1;
        chk("t3_c0_ready", src_ready, 4'b0001);
        tick(); put(0, 1, 0, 1, 32'hC1); #1;
        chk("t3_c1_ready", src_ready, 4'b0100);
        chk("t3_c0_flit", flit_out, fo(1, 0, 2'b01, 32'hC0));
        chk("t3_c0_busy", vc_busy, 2'b01);
        tick(); put(2, 1, 0, 1, 32'hD1); #1;
        chk("t3_c2_ready", src_ready, 4'b0001);
        chk("t3_c1_flit", flit_out, fo(1, 0, 2'b10, 32'hD0));
        chk("t3_c1_busy", vc_busy, 2'b11);
        tick(); put(0, 0, 0, 0, 32'h0); #1;
        chk("t3_c3_ready", src_ready, 4'b0100);
        chk("t3_c2_flit", flit_out, fo(0, 1, 2'b01, 32'hC1));
        chk("t3_c2_busy", vc_busy, 2'b10);
        tick(); put(2, 0, 0, 0, 32'h0); #1;
        chk("t3_c3_flit", flit_out, fo(0, 1, 2'b10, 32'hD1));
        chk("t3_c3_busy", vc_busy, 2'b00);

        // All VCs busy: third head waits for a tail, granted the cycle after
        rst();
        put(0, 1, 1, 0, 32'hE0);
        put(1, 1, 1, 0, 32'hF0);
        put(2, 1, 1, 0, 32'h60); #1;
        chk("t4_c0_ready", src_ready, 4'b0001);
        tick(); put(0, 1, 0, 1, 32'hE1); #1;
        chk("t4_c1_ready", src_ready, 4'b0010);
        chk("t4_c0_flit", flit_out, fo(1, 0, 2'b01, 32'hE0));
        tick(); put(1, 0, 0, 0, 32'h0); #1;
        chk("t4_c2_ready", src_ready, 4'b0001);
        chk("t4_c2_busy", vc_busy, 2'b11);
        chk("t4_c1_flit", flit_out, fo(1, 0, 2'b10, 32'hF0));
        tick(); put(0, 0, 0, 0, 32'h0); #1;
        chk("t4_c3_ready", src_ready, 4'b0100);
        chk("t4_c3_busy", vc_busy, 2'b10);
        chk("t4_c2_flit", flit_out, fo(0, 1, 2'b01, 32'hE1));
        tick(); put(2, 1, 0, 0, 32'h61); #1;
        chk("t4_c3_flit", flit_out, fo(1, 0, 2'b01, 32'h60));
        chk("t4_c4_busy", vc_busy, 2'b11);
        chk("t4_c4_ready", src_ready, 4'b0100);

        // Reset mid-packet: ownership dropped, body without head never granted
        reset = 1'b1;
        clr();
        put(1, 1, 0, 0, 32'hF1); #1;
        chk("t6_inrst_ready", src_ready, 4'b0000);
        tick(); #1;
        chk("t6_wr", flit_out_wr, 1'b0);
        chk("t6_busy", vc_busy, 2'b00);
        chk("t6_flit", flit_out, '0);
        reset = 1'b0; #1;
        chk("t6_body_ready", src_ready, 4'b0000);
        tick(); #1;
        chk("t6_body_ready2", src_ready, 4'b0000);
        chk("t6_body_wr", flit_out_wr, 1'b0);
        put(1, 1, 1, 0, 32'hF2); #1;
        chk("t6_head_ready", src_ready, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            tick(); put(1, 1, 0, 0, 32'hF3 + i); #1;
            chk("t6_cred_ready", src_ready, 4'b0010);
        end
        tick(); put(1, 1, 0, 0, 32'hF6); #1;
        chk("t6_cred4_stall", src_ready, 4'b0000);

        // Single-flit packets with matching credit return on VC0
        rst();
        for (int k = 0; k < 6; k++) begin
            put(0, 1, 1, 1, 32'h70 + k);
            credit_in = 2'b01; #1;
            chk("t5_ready", src_ready, 4'b0001);
            chk("t5_busy", vc_busy, 2'b00);
            if (k > 0) chk("t5_flit", flit_out, fo(1, 1, 2'b01, 32'h70 + k - 1));
            tick();
        end
        clr(); #1;
        chk("t5_last_flit", flit_out, fo(1, 1, 2'b01, 32'h75));
        chk("t5_last_wr", flit_out_wr, 1'b1);
        chk("t5_last_busy", vc_busy, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
